// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control path: widths, opcode map, sequencer
// state encodings and the opcode-class record produced by the decoder.
package cpu_sequencer_pkg;

  localparam int INSTW = 49;
  localparam int OPW   = 5;
  localparam int ADDRW = 6;

  localparam logic [OPW-1:0] OP_ALU_MAX = 5'h0F;
  localparam logic [OPW-1:0] OP_BZ      = 5'h10;
  localparam logic [OPW-1:0] OP_BNZ     = 5'h11;
  localparam logic [OPW-1:0] OP_BRA     = 5'h12;
  localparam logic [OPW-1:0] OP_STORE   = 5'h13;
  localparam logic [OPW-1:0] OP_HALT    = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_bz;
    logic is_bnz;
    logic is_bra;
    logic is_store;
    logic is_halt;
  } op_class_t;

  function automatic logic [OPW-1:0] opcode_of(input logic [INSTW-1:0] instr);
    return instr[INSTW-1 -: OPW];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the sequencer (slave) and the surrounding
// datapath / instruction memory (master).
interface cpu_sequencer_if;
  import cpu_sequencer_pkg::*;

  logic             run;
  logic             imem_ready;
  logic [INSTW-1:0] instr;
  logic             z_flag;
  logic             ir_load;
  logic             alu_en;
  logic             z_load;
  logic             rf_we;
  logic             mem_we;
  logic             pc_load;
  logic             pc_src;
  logic [ADDRW-1:0] pc_target;
  logic             halted;
  logic [2:0]       state_dbg;

  modport master (
    output run, imem_ready, instr, z_flag,
    input  ir_load, alu_en, z_load, rf_we, mem_we, pc_load, pc_src,
           pc_target, halted, state_dbg
  );

  modport slave (
    input  run, imem_ready, instr, z_flag,
    output ir_load, alu_en, z_load, rf_we, mem_we, pc_load, pc_src,
           pc_target, halted, state_dbg
  );

endinterface

// File: rtl/cpu_sequencer_op_class_decode.sv
// Combinational opcode classifier; anything not explicitly mapped is a NOP
// (all class bits low).
module cpu_sequencer_op_class_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output op_class_t      cls_o
);

  always_comb begin
    cls_o = '0;
    if (opcode_i <= OP_ALU_MAX) begin
      cls_o.is_alu = 1'b1;
    end else begin
      case (opcode_i)
        OP_BZ:    cls_o.is_bz    = 1'b1;
        OP_BNZ:   cls_o.is_bnz   = 1'b1;
        OP_BRA:   cls_o.is_bra   = 1'b1;
        OP_STORE: cls_o.is_store = 1'b1;
        OP_HALT:  cls_o.is_halt  = 1'b1;
        default:  cls_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC/UPDATE control FSM. Opcode class, branch target and Z are
// captured in DECODE so later phases decode only registered state.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cpu_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic             z_hold_q;
  op_class_t        cls_q;
  logic [ADDRW-1:0] target_q;

  op_class_t        dec_cls;
  logic [OPW-1:0]   opcode;
  logic             unused_instr_bits;

  assign opcode            = opcode_of(bus.instr);
  assign unused_instr_bits = ^bus.instr[INSTW-OPW-1:ADDRW];

  cpu_sequencer_op_class_decode u_decode (
    .opcode_i (opcode),
    .cls_o    (dec_cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      z_hold_q <= 1'b0;
      cls_q    <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      // Z sampled here still belongs to the previous instruction.
      if (state_q == S_DECODE) begin
        z_hold_q <= bus.z_flag;
        cls_q    <= dec_cls;
        target_q <= bus.instr[ADDRW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_cls.is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_UPDATE;
      S_UPDATE: state_d = bus.run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ir_load = 1'b0;
    bus.alu_en  = 1'b0;
    bus.z_load  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.pc_load = 1'b0;
    bus.rf_we   = 1'b0;
    bus.pc_src  = 1'b0;
    bus.halted  = 1'b0;
    case (state_q)
      // IR load is qualified by imem_ready so a zero-wait fetch costs one cycle.
      S_FETCH:  bus.ir_load = bus.imem_ready;
      S_EXEC: begin
        bus.alu_en = cls_q.is_alu;
        bus.z_load = cls_q.is_alu;
        bus.mem_we = cls_q.is_store;
      end
      S_UPDATE: begin
        bus.pc_load = 1'b1;
        bus.rf_we   = cls_q.is_alu;
        bus.pc_src  = cls_q.is_bra
                    | (cls_q.is_bz  &  z_hold_q)
                    | (cls_q.is_bnz & ~z_hold_q);
      end
      S_HALT:   bus.halted = 1'b1;
      default:  ;
    endcase
  end

  assign bus.pc_target = target_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus hand-written
// asynchronous-reset sequences.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam logic [7:0] IR = 8'h80, AL = 8'h40, ZL = 8'h20, RF = 8'h10;
  localparam logic [7:0] MW = 8'h08, PL = 8'h04, PS = 8'h02, HL = 8'h01;

  localparam logic [2:0] SI = 3'(S_IDLE), SF = 3'(S_FETCH), SD = 3'(S_DECODE);
  localparam logic [2:0] SE = 3'(S_EXEC), SU = 3'(S_UPDATE), SH = 3'(S_HALT);

  typedef struct {
    logic       run;
    logic       rdy;
    logic [4:0] op;
    logic [5:0] tgt;
    logic       z;
    logic [7:0] strb;
    logic [2:0] st;
    logic       chk_tgt;
    logic [5:0] etgt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [INSTW-1:0] mk(input logic [4:0] op, input logic [5:0] tgt);
    logic [INSTW-1:0] w;
    w = '0;
    w[INSTW-1 -: 5] = op;
    w[20:8] = 13'h1A5C;
    w[5:0] = tgt;
    return w;
  endfunction

  function automatic logic [7:0] strobes();
    return {bus.ir_load, bus.alu_en, bus.z_load, bus.rf_we,
            bus.mem_we, bus.pc_load, bus.pc_src, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic rdy, input logic [4:0] op, input logic [5:0] tgt,
                   input logic z, input logic [7:0] strb, input logic [2:0] st,
                   input logic ct = 1'b0, input logic [5:0] et = 6'h00);
    vec_t e;
    e.run = r; e.rdy = rdy; e.op = op; e.tgt = tgt; e.z = z;
    e.strb = strb; e.st = st; e.chk_tgt = ct; e.etgt = et;
    vecs.push_back(e);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.imem_ready = 1'b1;
    bus.instr = '0;
    bus.z_flag = 1'b0;

    // reset state
    v(0,1,5'h01,6'h05,0, 8'h00, SI, 1, 6'h00);
    // ALU 0x01: ir_load@c1, alu_en+z_load@c3, pc_load+rf_we@c4
    v(1,1,5'h01,6'h05,0, 8'h00,   SI);
    v(1,1,5'h01,6'h05,0, IR,      SF);
    v(1,1,5'h01,6'h05,0, 8'h00,   SD);
    v(1,1,5'h01,6'h05,1, AL|ZL,   SE);
    v(1,1,5'h01,6'h05,1, PL|RF,   SU);
    // BZ 0x2A with previous Z=1 -> taken; Z changes after DECODE must not matter
    v(1,1,5'h10,6'h2A,0, IR,      SF);
    v(1,1,5'h10,6'h2A,1, 8'h00,   SD);
    v(1,1,5'h10,6'h2A,0, 8'h00,   SE);
    v(1,1,5'h10,6'h2A,0, PL|PS,   SU, 1, 6'h2A);
    // BNZ 0x2A with Z=1 -> not taken
    v(1,1,5'h11,6'h2A,1, IR,      SF);
    v(1,1,5'h11,6'h2A,1, 8'h00,   SD);
    v(1,1,5'h11,6'h2A,0, 8'h00,   SE);
    v(1,1,5'h11,6'h2A,0, PL,      SU);
    // BNZ 0x15 with Z=0 -> taken
    v(1,1,5'h11,6'h15,0, IR,      SF);
    v(1,1,5'h11,6'h15,0, 8'h00,   SD);
    v(1,1,5'h11,6'h15,1, 8'h00,   SE);
    v(1,1,5'h11,6'h15,1, PL|PS,   SU, 1, 6'h15);
    // BRA 0x3F then NOP at 0x3F
    v(1,1,5'h12,6'h3F,1, IR,      SF);
    v(1,1,5'h12,6'h3F,1, 8'h00,   SD);
    v(1,1,5'h12,6'h3F,1, 8'h00,   SE);
    v(1,1,5'h12,6'h3F,1, PL|PS,   SU, 1, 6'h3F);
    v(1,1,5'h14,6'h00,0, IR,      SF);
    v(1,1,5'h14,6'h00,0, 8'h00,   SD);
    v(1,1,5'h14,6'h00,0, 8'h00,   SE);
    v(1,1,5'h14,6'h00,0, PL,      SU);
    // STORE
    v(1,1,5'h13,6'h07,0, IR,      SF);
    v(1,1,5'h13,6'h07,0, 8'h00,   SD);
    v(1,1,5'h13,6'h07,0, MW,      SE);
    v(1,1,5'h13,6'h07,0, PL,      SU);
    // ALU 0x0F with 3 wait states, run dropped mid-instruction -> parks in IDLE
    v(1,0,5'h0F,6'h09,0, 8'h00,   SF);
    v(1,0,5'h0F,6'h09,0, 8'h00,   SF);
    v(1,0,5'h0F,6'h09,0, 8'h00,   SF);
    v(1,1,5'h0F,6'h09,0, IR,      SF);
    v(1,1,5'h0F,6'h09,0, 8'h00,   SD);
    v(0,1,5'h0F,6'h09,0, AL|ZL,   SE);
    v(0,1,5'h0F,6'h09,0, PL|RF,   SU);
    v(0,1,5'h0F,6'h09,0, 8'h00,   SI);
    v(0,1,5'h0F,6'h09,0, 8'h00,   SI);
    // HALT: no pc_load, run ignored
    v(1,1,5'h1F,6'h00,0, 8'h00,   SI);
    v(1,1,5'h1F,6'h00,0, IR,      SF);
    v(1,1,5'h1F,6'h00,0, 8'h00,   SD);
    v(1,1,5'h1F,6'h00,0, HL,      SH);
    v(1,1,5'h1F,6'h00,0, HL,      SH);
    v(0,1,5'h1F,6'h00,0, HL,      SH);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      bus.run = vecs[i].run;
      bus.imem_ready = vecs[i].rdy;
      bus.instr = mk(vecs[i].op, vecs[i].tgt);
      bus.z_flag = vecs[i].z;
      @(negedge clk);
      chk($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].strb));
      chk($sformatf("vec%0d state", i), 32'(bus.state_dbg), 32'(vecs[i].st));
      if (vecs[i].chk_tgt)
        chk($sformatf("vec%0d pc_target", i), 32'(bus.pc_target), 32'(vecs[i].etgt));
      $display("vec %0d op=%02h st=%0d strb=%02h tgt=%02h", i, vecs[i].op,
               bus.state_dbg, strobes(), bus.pc_target);
      @(posedge clk);
      #1;
    end

    // async reset out of HALT
    #2 rst = 1'b1;
    #1;
    chk("halt_rst halted", 32'(bus.halted), 32'd0);
    chk("halt_rst state", 32'(bus.state_dbg), 32'(SI));
    $display("halt reset: st=%0d halted=%0b", bus.state_dbg, bus.halted);
    @(posedge clk);
    #1 rst = 1'b0;

    // async reset during EXEC of a STORE
    bus.run = 1'b1;
    bus.imem_ready = 1'b1;
    bus.instr = mk(5'h13, 6'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("store exec mem_we", 32'(bus.mem_we), 32'd1);
    chk("store exec state", 32'(bus.state_dbg), 32'(SE));
    #2 rst = 1'b1;
    #1;
    chk("store rst strobes", 32'(strobes()), 32'd0);
    chk("store rst state", 32'(bus.state_dbg), 32'(SI));
    $display("store reset: st=%0d strb=%02h", bus.state_dbg, strobes());
    @(posedge clk);
    #1;
    chk("store rst held", 32'(bus.state_dbg), 32'(SI));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart fetch", 32'(bus.state_dbg), 32'(SF));
    chk("restart ir_load", 32'(bus.ir_load), 32'd1);
    $display("restart: st=%0d ir_load=%0b", bus.state_dbg, bus.ir_load);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
